// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and helpers for the streaming neuron blocks
//
// Contents:
//   state_t    : frame FSM states (ST_ACC accumulating, ST_OUT holding a result)
//   acc_width  : accumulator width DW + clog2(N_IN), wide enough that the sum never overflows
//   relu_sat   : ReLU then optional unsigned saturation of a sign-extended value to out_w bits
package neuron_pkg;

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  function automatic int acc_width(input int dw, input int n_in);
    return dw + $clog2(n_in);
  endfunction

  // t is carried at 64 bits so one function serves every accumulator width;
  // callers sign-extend into it and truncate the result to out_w bits.
  function automatic logic [63:0] relu_sat(input logic signed [63:0] t,
                                            input int out_w,
                                            input bit sat);
    logic [63:0] max_val;
    logic [63:0] r;
    max_val = (64'd1 << out_w) - 64'd1;
    if (t[63]) begin
      r = 64'd0;
    end else if ($unsigned(t) > max_val) begin
      r = sat ? max_val : ($unsigned(t) & max_val);
    end else begin
      r = $unsigned(t);
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_stream_relu_if.sv
// rtl/neuron_stream_relu_if.sv - input/output valid-ready streams of the neuron
//
// Signals:
//   in_valid/in_ready/in_data    : signed DW-bit sample stream into the neuron
//   out_valid/out_ready/out_q    : unsigned OUT_W-bit result stream out of the neuron
//   out_neg                      : shifted sum was negative, valid with out_valid
// Modports: master = stream source/sink side, slave = neuron side.
interface neuron_stream_relu_if #(
  parameter int DW    = 8,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_q;
  logic             out_neg;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_q, out_neg
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_q, out_neg
  );
endinterface

// File: rtl/neuron_relu_sat.sv
// rtl/neuron_relu_sat.sv - combinational arithmetic shift, ReLU and saturate stage
//
// Ports:
//   sum : signed AW-bit accumulated sum
//   q   : OUT_W-bit result after >>> SHIFT, ReLU and saturation/wrap
//   neg : shifted sum was negative
module neuron_relu_sat
  import neuron_pkg::*;
#(
  parameter int AW    = 11,
  parameter int SHIFT = 2,
  parameter int OUT_W = 8,
  parameter int SAT   = 1
) (
  input  logic signed [AW-1:0] sum,
  output logic [OUT_W-1:0]     q,
  output logic                 neg
);

  logic signed [AW-1:0] t;

  // Arithmetic shift rounds toward -inf, so e.g. -3 >>> 2 = -1 (negative).
  assign t   = sum >>> SHIFT;
  assign neg = t[AW-1];
  assign q   = OUT_W'(relu_sat(64'(t), OUT_W, SAT != 0));

endmodule

// File: rtl/neuron_stream_relu.sv
// rtl/neuron_stream_relu.sv - time-multiplexed N_IN-input ReLU neuron on valid/ready streams
//
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   clear : synchronous frame abort while accumulating (ignored while a result is held)
//   bus   : slave side of the sample/result streams (see neuron_stream_relu_if)
module neuron_stream_relu
  import neuron_pkg::*;
#(
  parameter int DW    = 8,
  parameter int N_IN  = 8,
  parameter int SHIFT = 2,
  parameter int OUT_W = 8,
  parameter int SAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  neuron_stream_relu_if.slave  bus
);

  localparam int AW = acc_width(DW, N_IN);
  localparam int CW = $clog2(N_IN);

  state_t               state, state_nxt;
  logic signed [AW-1:0] acc, acc_nxt, sum;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [OUT_W-1:0]     q_reg, q_res;
  logic                 neg_reg, neg_res;
  logic                 beat, last, load;

  assign beat = bus.in_valid && (state == ST_ACC);
  assign last = (cnt == CW'(N_IN - 1));
  assign sum  = acc + {{(AW-DW){bus.in_data[DW-1]}}, bus.in_data};

  neuron_relu_sat #(
    .AW    (AW),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .SAT   (SAT)
  ) u_relu_sat (
    .sum (sum),
    .q   (q_res),
    .neg (neg_res)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      ST_ACC: begin
        // clear beats everything, including a last beat in the same cycle
        if (clear) begin
          acc_nxt = '0;
          cnt_nxt = '0;
        end else if (beat) begin
          if (last) begin
            load      = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ST_OUT;
          end else begin
            acc_nxt = sum;
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_OUT: begin
        if (bus.out_ready) state_nxt = ST_ACC;
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_ACC;
      acc     <= '0;
      cnt     <= '0;
      q_reg   <= '0;
      neg_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        q_reg   <= q_res;
        neg_reg <= neg_res;
      end
    end
  end

  // Both handshake outputs come straight from the state register.
  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_q     = q_reg;
  assign bus.out_neg   = neg_reg;

endmodule

// File: tb/tb_neuron_stream_relu.sv
// tb/tb_neuron_stream_relu.sv - bench for neuron_stream_relu in three parameter sets
module tb_neuron_stream_relu;
  import neuron_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // d = defaults, s = SHIFT 0 SAT 1, w = SHIFT 0 SAT 0; all fed identically
  neuron_stream_relu_if #(.DW(8), .OUT_W(8)) if_d ();
  neuron_stream_relu_if #(.DW(8), .OUT_W(8)) if_s ();
  neuron_stream_relu_if #(.DW(8), .OUT_W(8)) if_w ();

  assign if_d.in_valid = in_valid;  assign if_d.in_data = in_data;  assign if_d.out_ready = out_ready;
  assign if_s.in_valid = in_valid;  assign if_s.in_data = in_data;  assign if_s.out_ready = out_ready;
  assign if_w.in_valid = in_valid;  assign if_w.in_data = in_data;  assign if_w.out_ready = out_ready;

  neuron_stream_relu #(.DW(8), .N_IN(8), .SHIFT(2), .OUT_W(8), .SAT(1)) u_d (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_d));
  neuron_stream_relu #(.DW(8), .N_IN(8), .SHIFT(0), .OUT_W(8), .SAT(1)) u_s (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_s));
  neuron_stream_relu #(.DW(8), .N_IN(8), .SHIFT(0), .OUT_W(8), .SAT(0)) u_w (
    .clk(clk), .rst(rst), .clear(clear), .bus(if_w));

  typedef struct packed {
    logic [7:0][7:0] beats;
    logic [7:0]      q_d;
    logic            neg_d;
    logic [7:0]      q_s;
    logic [7:0]      q_w;
    logic            neg_0;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7,
                              input logic [7:0] q_d, input logic neg_d,
                              input logic [7:0] q_s, input logic [7:0] q_w,
                              input logic neg_0);
    vec_t v;
    v.beats = {b7, b6, b5, b4, b3, b2, b1, b0};
    v.q_d = q_d; v.neg_d = neg_d; v.q_s = q_s; v.q_w = q_w; v.neg_0 = neg_0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!if_d.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL beat_wait: in_ready stuck low for %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input vec_t v);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check({name, "_early_valid"}, {31'd0, if_d.out_valid}, 32'd0);
      send_beat(v.beats[i]);
    end
    check({name, "_valid_d"}, {31'd0, if_d.out_valid}, 32'd1);
    check({name, "_valid_s"}, {31'd0, if_s.out_valid}, 32'd1);
    check({name, "_q_d"},     {24'd0, if_d.out_q},     {24'd0, v.q_d});
    check({name, "_neg_d"},   {31'd0, if_d.out_neg},   {31'd0, v.neg_d});
    check({name, "_q_s"},     {24'd0, if_s.out_q},     {24'd0, v.q_s});
    check({name, "_q_w"},     {24'd0, if_w.out_q},     {24'd0, v.q_w});
    check({name, "_neg_s"},   {31'd0, if_s.out_neg},   {31'd0, v.neg_0});
    check({name, "_in_ready"},{31'd0, if_d.in_ready},  32'd0);
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, {31'd0, if_d.out_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, if_d.in_ready},  32'd1);
  endtask

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk(10, 10, 10, 10, 10, 10, 10, 10,             20, 0,  80,  80, 0);
    tbl[1] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 0, 0, 1);
    tbl[2] = mk(3, 8'hFD, 5, 8'hFB, 0, 0, 1, 2,              0, 0,   3,   3, 0);
    tbl[3] = mk(127, 127, 127, 127, 127, 127, 127, 127,    254, 0, 255, 8'hF8, 0);
    tbl[4] = mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 0, 1, 0, 0, 1);
    tbl[5] = mk(127, 127, 127, 127, 0, 0, 0, 2,            127, 0, 255, 254, 0);
    tbl[6] = mk(8'hFD, 0, 0, 0, 0, 0, 0, 0,                  0, 1,   0,   0, 1);
    tbl[7] = mk(4, 0, 0, 0, 0, 0, 0, 0,                      1, 0,   4,   4, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, if_d.out_valid}, 32'd0);
    check("rst_q",     {24'd0, if_d.out_q},     32'd0);
    check("rst_neg",   {31'd0, if_d.out_neg},   32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, if_d.in_ready}, 32'd1);

    for (int k = 0; k < 8; k++) begin
      run_frame($sformatf("vec%0d", k), tbl[k]);
      release_out($sformatf("vec%0d", k));
    end

    // back-pressure: result held, offered beats not consumed
    run_frame("bp", mk(10, 10, 10, 10, 10, 10, 10, 10, 20, 0, 80, 80, 0));
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_in_ready", {31'd0, if_d.in_ready},  32'd0);
      check("bp_valid",    {31'd0, if_d.out_valid}, 32'd1);
      check("bp_q",        {24'd0, if_d.out_q},     32'd20);
    end
    in_valid = 1'b0;
    release_out("bp");
    run_frame("bp_next", mk(1, 1, 1, 1, 1, 1, 1, 1, 2, 0, 8, 8, 0));
    release_out("bp_next");

    // clear mid-frame, including the beat offered in the clear cycle
    for (int i = 0; i < 3; i++) send_beat(8'd50);
    in_valid = 1'b1;
    in_data  = 8'd50;
    clear    = 1'b1;
    check("clr_in_ready", {31'd0, if_d.in_ready}, 32'd1);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    run_frame("clr", mk(4, 4, 4, 4, 4, 4, 4, 4, 8, 0, 32, 32, 0));
    release_out("clr");

    // clear together with the last beat: no result
    for (int i = 0; i < 7; i++) send_beat(8'd10);
    in_valid = 1'b1;
    in_data  = 8'd10;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_last_valid", {31'd0, if_d.out_valid}, 32'd0);
    check("clr_last_ready", {31'd0, if_d.in_ready},  32'd1);
    run_frame("clr_last_next", mk(3, 3, 3, 3, 3, 3, 3, 3, 6, 0, 24, 24, 0));

    // clear while holding a result has no effect
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_out_valid", {31'd0, if_d.out_valid}, 32'd1);
    check("clr_out_q",     {24'd0, if_d.out_q},     32'd6);
    release_out("clr_out");

    // reset mid-frame
    for (int i = 0; i < 5; i++) send_beat(8'd10);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, if_d.out_valid}, 32'd0);
    check("rst_mid_q",     {24'd0, if_d.out_q},     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, if_d.in_ready}, 32'd1);

    // reset while holding a result
    run_frame("rst_out_pre", mk(10, 10, 10, 10, 10, 10, 10, 10, 20, 0, 80, 80, 0));
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, if_d.out_valid}, 32'd0);
    check("rst_out_q",     {24'd0, if_d.out_q},     32'd0);
    check("rst_out_neg",   {31'd0, if_d.out_neg},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_out_ready", {31'd0, if_d.in_ready}, 32'd1);
    run_frame("rst_after", mk(2, 2, 2, 2, 2, 2, 2, 2, 4, 0, 16, 16, 0));
    release_out("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_stream_relu.md
Name: neuron_stream_relu

Overview:
- Parametrised, time-multiplexed successor to the eight-input combinational ReLU neuron.
- Accepts N_IN signed DW-bit inputs serially over a valid/ready stream and accumulates them at full precision.
- Applies an arithmetic right shift, then ReLU, then unsigned saturation to OUT_W bits.
- Presents one result per frame on a valid/ready output; sits between the feature-stream source and the next neuron layer.

Parameters:
- DW, 8, input sample width (two's complement).
- N_IN, 8, number of inputs summed per frame (>=2).
- SHIFT, 2, arithmetic right shift applied to the sum before ReLU (0..AW-1).
- OUT_W, 8, output width (unsigned).
- SAT, 1, 1 = clamp positive overflow to 2^OUT_W-1; 0 = keep the low OUT_W bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous frame abort; discards the partial sum.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DW  signed input sample.
- out_valid  out  1  out_q is valid.
- out_ready  in  1  downstream accepts out_q.
- out_q  out  OUT_W  ReLU/saturated result.
- out_neg  out  1  pre-ReLU shifted sum was negative (status, valid with out_valid).

Behaviour:
- Widths: AW = DW + clog2(N_IN), signed. The accumulator never overflows. Count width is clog2(N_IN).
- States: ACC and OUT.
- Reset: state = ACC, acc = 0, cnt = 0, out_valid = 0, out_q = 0, out_neg = 0. in_ready = 1 once rst deasserts.
- ACC:
  - in_ready = 1, out_valid = 0.
  - A beat is accepted when in_valid & in_ready. Then acc += sext(in_data) and cnt += 1.
  - On the beat accepted with cnt == N_IN-1, the final sum s = acc + sext(in_data) is computed and the result is registered in the same edge.
  - Result: t = s >>> SHIFT (arithmetic, rounds toward -inf). out_neg = t < 0. out_q = 0 if t < 0. Otherwise, if t > 2^OUT_W-1: out_q = all ones when SAT = 1, else t[OUT_W-1:0]. Otherwise out_q = t[OUT_W-1:0].
  - State -> OUT. acc and cnt clear to 0.
- OUT:
  - in_ready = 0, out_valid = 1.
  - out_q and out_neg stay stable until the handshake.
  - On out_ready: state -> ACC and out_valid drops next cycle.
- Latency: out_valid rises the cycle after the last input beat is accepted.
- Throughput: at most one result per N_IN+1 cycles. There is no overlap of output hold and the next frame.
- Gaps in in_valid are allowed. acc and cnt hold while in_valid = 0.
- clear:
  - In ACC it zeroes acc and cnt, and any beat in that cycle is dropped. in_ready stays 1.
  - In OUT it has no effect; a completed result is never discarded.
  - clear and the last beat in the same cycle: clear wins, no result, state stays ACC.
- rst mid-frame or during OUT: immediate return to the reset values. A pending result is lost.
- out_valid never depends combinationally on out_ready. in_ready is a function of state only.

Decomposition:
- Package neuron_pkg holds:
  - function relu_sat(t, OUT_W, SAT), shared with future neuron variants;
  - the state enum {ST_ACC, ST_OUT};
  - the clog2-based AW helper constant.
- One sub-module, neuron_relu_sat: a combinational shift, ReLU and saturate stage parameterised by AW/SHIFT/OUT_W/SAT. It is reused by the planned multi-lane variant.
- The accumulator, counter and FSM stay in the top.

Test Plan:
- Defaults; eight beats of 10 -> out_q = 20, out_neg = 0, out_valid one cycle after the 8th beat.
- Defaults; eight beats of -1 (sum -8, t = -2) -> out_q = 0, out_neg = 1. Then beats 3,-3,5,-5,0,0,1,2 (sum 3, t = 0) -> out_q = 0, out_neg = 0.
- SHIFT = 0, SAT = 1; eight beats of 127 (1016) -> out_q = 255. Same with SAT = 0 -> out_q = 0xF8.
- Back-pressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, out_q stable, no beats consumed. Release -> next frame starts cleanly with acc = 0.
- Three beats of 50, then clear with in_valid = 1, then eight beats of 4 -> single result out_q = 8; the 50s and the cleared-cycle beat are discarded.
- Assert rst after five beats and again during OUT -> all outputs 0 immediately, in_ready = 1 after release. The next eight beats of 2 -> out_q = 4.
